dm_sba_arbiter: RTL and testbench



---
 rtl/dm_sba_arbiter.sv | 149 ++++++++++++++
 tb/tb_dm_sba_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_sba_arbiter.sv
// dm_sba_arbiter: shares the debug-module bus master port between the SBA
// engine (requester 0) and a second initiator (requester 1).
// One request is forwarded at a time, and a request that has not yet been
// granted keeps its selection. Responses are steered back in grant order
// through an in-order ID FIFO.
// Optional feature: define DM_SBA_ARB_FIXED_PRIO_EN to give requester 0
// fixed priority and drop the round-robin pointer.
module dm_sba_arbiter #(
  parameter int unsigned BusWidth       = 32,
  parameter int unsigned MaxOutstanding = 2
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [1:0]                    req_i,
  input  logic [2*BusWidth-1:0]         add_i,
  input  logic [1:0]                    we_i,
  input  logic [2*BusWidth-1:0]         wdata_i,
  input  logic [2*(BusWidth/8)-1:0]     be_i,
  output logic [1:0]                    gnt_o,
  output logic [1:0]                    r_valid_o,
  output logic [BusWidth-1:0]           r_rdata_o,
  output logic                          master_req_o,
  output logic [BusWidth-1:0]           master_add_o,
  output logic                          master_we_o,
  output logic [BusWidth-1:0]           master_wdata_o,
  output logic [BusWidth/8-1:0]         master_be_o,
  input  logic                          master_gnt_i,
  input  logic                          master_r_valid_i,
  input  logic [BusWidth-1:0]           master_r_rdata_i,
  output logic                          spurious_o
);

  localparam int unsigned BeWidth  = BusWidth / 8;
  localparam int unsigned PtrWidth = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam int unsigned CntWidth = $clog2(MaxOutstanding + 1);
  localparam logic [PtrWidth-1:0] PtrLast = PtrWidth'(MaxOutstanding - 1);
  localparam logic [CntWidth-1:0] CntMax  = CntWidth'(MaxOutstanding);

  logic                      sel;
  logic                      sel_unlocked;
  logic                      locked_q;
  logic                      lock_id_q;
  logic [MaxOutstanding-1:0] id_fifo_q;
  logic [PtrWidth-1:0]       wr_ptr_q;
  logic [PtrWidth-1:0]       rd_ptr_q;
  logic [CntWidth-1:0]       cnt_q;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic                      push;
  logic                      pop;
  logic                      head;

`ifndef DM_SBA_ARB_FIXED_PRIO_EN
  logic rr_q;
`endif

  assign fifo_full  = (cnt_q == CntMax);
  assign fifo_empty = (cnt_q == '0);
  assign head       = id_fifo_q[rd_ptr_q];

  // Requester selection; a pending ungranted request keeps its selection.
  always_comb begin
    sel_unlocked = 1'b0;
`ifdef DM_SBA_ARB_FIXED_PRIO_EN
    sel_unlocked = ~req_i[0] & req_i[1];
`else
    if (req_i[rr_q]) begin
      sel_unlocked = rr_q;
    end else if (req_i[~rr_q]) begin
      sel_unlocked = ~rr_q;
    end else begin
      sel_unlocked = rr_q;
    end
`endif
    sel = locked_q ? lock_id_q : sel_unlocked;
  end

  // Request forwarding and payload mux; nothing is forwarded while the ID FIFO is full.
  always_comb begin
    master_req_o   = req_i[sel] & ~fifo_full;
    master_add_o   = sel ? add_i[2*BusWidth-1:BusWidth]   : add_i[BusWidth-1:0];
    master_wdata_o = sel ? wdata_i[2*BusWidth-1:BusWidth] : wdata_i[BusWidth-1:0];
    master_be_o    = sel ? be_i[2*BeWidth-1:BeWidth]      : be_i[BeWidth-1:0];
    master_we_o    = we_i[sel];
    gnt_o          = 2'b00;
    gnt_o[sel]     = master_gnt_i & master_req_o;
  end

  assign push = master_req_o & master_gnt_i;
  assign pop  = master_r_valid_i & ~fifo_empty;

  // Response steering: the FIFO head names the requester that owns this response.
  always_comb begin
    r_valid_o = 2'b00;
    if (pop) begin
      r_valid_o[head] = 1'b1;
    end
    r_rdata_o  = master_r_rdata_i;
    spurious_o = master_r_valid_i & fifo_empty;
  end

  // Lock a selection that is requesting but not yet granted; a dropped request also clears it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      locked_q  <= 1'b0;
      lock_id_q <= 1'b0;
    end else begin
      locked_q <= master_req_o & ~master_gnt_i;
      if (master_req_o && !master_gnt_i) begin
        lock_id_q <= sel;
      end
    end
  end

`ifndef DM_SBA_ARB_FIXED_PRIO_EN
  // Round-robin pointer: the requester that was not just granted gets priority.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q <= 1'b0;
    end else if (push) begin
      rr_q <= ~sel;
    end
  end
`endif

  // In-order ID FIFO of granted requesters, with an occupancy counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      id_fifo_q <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
    end else begin
      if (push) begin
        id_fifo_q[wr_ptr_q] <= sel;
        wr_ptr_q <= (wr_ptr_q == PtrLast) ? '0 : wr_ptr_q + PtrWidth'(1);
      end
      if (pop) begin
        rd_ptr_q <= (rd_ptr_q == PtrLast) ? '0 : rd_ptr_q + PtrWidth'(1);
      end
      if (push && !pop && (cnt_q != CntMax)) begin
        cnt_q <= cnt_q + CntWidth'(1);
      end else if (pop && !push && (cnt_q != '0)) begin
        cnt_q <= cnt_q - CntWidth'(1);
      end
    end
  end

endmodule

// File: tb/tb_dm_sba_arbiter.sv
// Bench for dm_sba_arbiter: expected response owners are queued at grant
// time and checked against r_valid_o when the bus response is driven.
module tb_dm_sba_arbiter;

  localparam int unsigned BW = 32;
  localparam int unsigned BE = BW / 8;

  logic            clk = 1'b0;
  logic            rst_ni;
  logic [1:0]      req_i;
  logic [2*BW-1:0] add_i;
  logic [1:0]      we_i;
  logic [2*BW-1:0] wdata_i;
  logic [2*BE-1:0] be_i;
  logic [1:0]      gnt_o;
  logic [1:0]      r_valid_o;
  logic [BW-1:0]   r_rdata_o;
  logic            master_req_o;
  logic [BW-1:0]   master_add_o;
  logic            master_we_o;
  logic [BW-1:0]   master_wdata_o;
  logic [BE-1:0]   master_be_o;
  logic            master_gnt_i;
  logic            master_r_valid_i;
  logic [BW-1:0]   master_r_rdata_i;
  logic            spurious_o;

  int   n_tests = 0;
  int   n_fail  = 0;
  logic exp_q[$];
  logic mdl_rr  = 1'b0;

  always #5 clk = ~clk;

  dm_sba_arbiter #(.BusWidth(BW), .MaxOutstanding(2)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .req_i(req_i), .add_i(add_i), .we_i(we_i),
    .wdata_i(wdata_i), .be_i(be_i), .gnt_o(gnt_o), .r_valid_o(r_valid_o),
    .r_rdata_o(r_rdata_o), .master_req_o(master_req_o), .master_add_o(master_add_o),
    .master_we_o(master_we_o), .master_wdata_o(master_wdata_o), .master_be_o(master_be_o),
    .master_gnt_i(master_gnt_i), .master_r_valid_i(master_r_valid_i),
    .master_r_rdata_i(master_r_rdata_i), .spurious_o(spurious_o)
  );

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  // Pop the expected owner and compare the steered response (called at the sample point).
  task automatic test_response(input string name, input logic [BW-1:0] data);
    logic       id;
    logic [1:0] exp_oh;
    n_tests++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s_scoreboard: got r_valid_o=%b, required a queued grant", name, r_valid_o);
      return;
    end
    id = exp_q.pop_front();
    exp_oh = id ? 2'b10 : 2'b01;
    if (r_valid_o !== exp_oh) begin
      n_fail++;
      $display("FAIL %s_r_valid: got %b, required %b", name, r_valid_o, exp_oh);
    end
    n_tests++;
    if (r_rdata_o !== data || spurious_o !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_rdata: got %h spurious=%b, required %h spurious=0", name, r_rdata_o, spurious_o, data);
    end
  endtask

  task automatic test_reset;
    rst_ni = 1'b0;
    req_i = 2'b00; master_gnt_i = 1'b0; master_r_valid_i = 1'b0; master_r_rdata_i = '0;
    add_i = {32'h0000_0200, 32'h0000_0100};
    we_i = 2'b10; wdata_i = {32'hAAAA_0001, 32'h5555_0000}; be_i = 8'hF3;
    @(negedge clk);
    n_tests++;
    if (master_req_o !== 1'b0 || gnt_o !== 2'b00 || r_valid_o !== 2'b00 || spurious_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got req=%b gnt=%b rv=%b sp=%b, required 0 00 00 0",
               master_req_o, gnt_o, r_valid_o, spurious_o);
    end
    n_tests++;
    if (master_add_o !== 32'h100 || master_we_o !== 1'b0 || master_wdata_o !== 32'h5555_0000 || master_be_o !== 4'h3) begin
      n_fail++;
      $display("FAIL reset_payload: got add=%h we=%b wd=%h be=%h, required 100 0 55550000 3",
               master_add_o, master_we_o, master_wdata_o, master_be_o);
    end
    rst_ni = 1'b1;
    next_cycle();
  endtask

  task automatic test_single;
    req_i = 2'b01; add_i = {32'h0, 32'h0000_0100}; we_i = 2'b00; master_gnt_i = 1'b1;
    @(negedge clk);
    n_tests++;
    if (gnt_o !== 2'b01 || master_req_o !== 1'b1 || master_add_o !== 32'h100) begin
      n_fail++;
      $display("FAIL single_grant: got gnt=%b req=%b add=%h, required 01 1 100", gnt_o, master_req_o, master_add_o);
    end
    exp_q.push_back(1'b0); mdl_rr = 1'b1;
    next_cycle();
    req_i = 2'b00; master_gnt_i = 1'b0;
    @(negedge clk);
    n_tests++;
    if (gnt_o !== 2'b00 || r_valid_o !== 2'b00) begin
      n_fail++;
      $display("FAIL single_idle: got gnt=%b rv=%b, required 00 00", gnt_o, r_valid_o);
    end
    next_cycle();
    master_r_valid_i = 1'b1; master_r_rdata_i = 32'hDEAD_BEEF;
    @(negedge clk);
    test_response("single", 32'hDEAD_BEEF);
    next_cycle();
    master_r_valid_i = 1'b0;
  endtask

  task automatic test_full;
    logic [BW-1:0] d;
    req_i = 2'b01; add_i = {32'h0, 32'h0000_0300}; master_gnt_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_tests++;
      if (gnt_o !== 2'b01) begin
        n_fail++;
        $display("FAIL full_fill%0d: got gnt=%b, required 01", i, gnt_o);
      end
      exp_q.push_back(1'b0); mdl_rr = 1'b1;
      next_cycle();
    end
    @(negedge clk);
    n_tests++;
    if (master_req_o !== 1'b0 || gnt_o !== 2'b00) begin
      n_fail++;
      $display("FAIL full_block: got req=%b gnt=%b, required 0 00", master_req_o, gnt_o);
    end
    next_cycle();
    d = $urandom(); master_r_valid_i = 1'b1; master_r_rdata_i = d;
    @(negedge clk);
    n_tests++;
    if (master_req_o !== 1'b0) begin
      n_fail++;
      $display("FAIL full_pop_cycle: got req=%b, required 0", master_req_o);
    end
    test_response("full_pop", d);
    next_cycle();
    master_r_valid_i = 1'b0;
    @(negedge clk);
    n_tests++;
    if (master_req_o !== 1'b1 || gnt_o !== 2'b01) begin
      n_fail++;
      $display("FAIL full_resume: got req=%b gnt=%b, required 1 01", master_req_o, gnt_o);
    end
    exp_q.push_back(1'b0); mdl_rr = 1'b1;
    next_cycle();
    req_i = 2'b00; master_gnt_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      d = $urandom(); master_r_valid_i = 1'b1; master_r_rdata_i = d;
      @(negedge clk);
      test_response("full_drain", d);
      next_cycle();
    end
    master_r_valid_i = 1'b0;
  endtask

  task automatic test_spurious;
    master_r_valid_i = 1'b1; master_r_rdata_i = 32'h1234_5678;
    @(negedge clk);
    n_tests++;
    if (spurious_o !== 1'b1 || r_valid_o !== 2'b00) begin
      n_fail++;
      $display("FAIL spurious_pulse: got sp=%b rv=%b, required 1 00", spurious_o, r_valid_o);
    end
    next_cycle();
    master_r_valid_i = 1'b0;
    @(negedge clk);
    n_tests++;
    if (spurious_o !== 1'b0) begin
      n_fail++;
      $display("FAIL spurious_clear: got sp=%b, required 0", spurious_o);
    end
    next_cycle();
  endtask

  task automatic test_reset_mid;
    req_i = 2'b01; add_i = {32'h0000_0B00, 32'h0000_0A00}; master_gnt_i = 1'b1;
    @(negedge clk);
    n_tests++;
    if (gnt_o !== 2'b01) begin
      n_fail++;
      $display("FAIL rstmid_grant: got gnt=%b, required 01", gnt_o);
    end
    next_cycle();
    req_i = 2'b00; master_gnt_i = 1'b0;
    rst_ni = 1'b0;
    exp_q.delete(); mdl_rr = 1'b0;
    @(negedge clk);
    n_tests++;
    if (master_req_o !== 1'b0 || gnt_o !== 2'b00 || r_valid_o !== 2'b00 || spurious_o !== 1'b0 || master_add_o !== 32'hA00) begin
      n_fail++;
      $display("FAIL rstmid_outputs: got req=%b gnt=%b rv=%b sp=%b add=%h, required 0 00 00 0 a00",
               master_req_o, gnt_o, r_valid_o, spurious_o, master_add_o);
    end
    rst_ni = 1'b1;
    next_cycle();
    master_r_valid_i = 1'b1; master_r_rdata_i = 32'h0BAD_0BAD;
    @(negedge clk);
    n_tests++;
    if (spurious_o !== 1'b1 || r_valid_o !== 2'b00) begin
      n_fail++;
      $display("FAIL rstmid_spurious: got sp=%b rv=%b, required 1 00", spurious_o, r_valid_o);
    end
    next_cycle();
    master_r_valid_i = 1'b0;
  endtask

  task automatic test_contention;
    logic          exp_sel;
    logic [1:0]    exp_oh;
    logic [BW-1:0] a0, a1, d;
    req_i = 2'b11; master_gnt_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a0 = 32'h1000 + 32'(i * 4); a1 = 32'h2000 + 32'(i * 4);
      add_i = {a1, a0};
      d = $urandom();
      master_r_valid_i = (i > 0); master_r_rdata_i = d;
`ifdef DM_SBA_ARB_FIXED_PRIO_EN
      exp_sel = 1'b0;
`else
      exp_sel = mdl_rr;
`endif
      exp_oh = exp_sel ? 2'b10 : 2'b01;
      @(negedge clk);
      n_tests++;
      if (gnt_o !== exp_oh || master_add_o !== (exp_sel ? a1 : a0)) begin
        n_fail++;
        $display("FAIL contention_grant%0d: got gnt=%b add=%h, required %b %h",
                 i, gnt_o, master_add_o, exp_oh, exp_sel ? a1 : a0);
      end
      if (i > 0) test_response("contention", d);
      exp_q.push_back(exp_sel); mdl_rr = ~exp_sel;
      next_cycle();
    end
    req_i = 2'b00; master_gnt_i = 1'b0;
    d = $urandom(); master_r_valid_i = 1'b1; master_r_rdata_i = d;
    @(negedge clk);
    test_response("contention_last", d);
    next_cycle();
    master_r_valid_i = 1'b0;
  endtask

  task automatic test_lock;
    logic [BW-1:0] d;
    req_i = 2'b10; add_i = {32'h2222_0000, 32'h1111_0000}; master_gnt_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i == 1) req_i = 2'b11;
      @(negedge clk);
      n_tests++;
      if (master_add_o !== 32'h2222_0000 || gnt_o !== 2'b00 || master_req_o !== 1'b1) begin
        n_fail++;
        $display("FAIL lock_hold%0d: got add=%h gnt=%b req=%b, required 22220000 00 1",
                 i, master_add_o, gnt_o, master_req_o);
      end
      next_cycle();
    end
    master_gnt_i = 1'b1;
    @(negedge clk);
    n_tests++;
    if (gnt_o !== 2'b10 || master_add_o !== 32'h2222_0000) begin
      n_fail++;
      $display("FAIL lock_grant: got gnt=%b add=%h, required 10 22220000", gnt_o, master_add_o);
    end
    exp_q.push_back(1'b1); mdl_rr = 1'b0;
    next_cycle();
    @(negedge clk);
    n_tests++;
    if (gnt_o !== 2'b01 || master_add_o !== 32'h1111_0000) begin
      n_fail++;
      $display("FAIL lock_next: got gnt=%b add=%h, required 01 11110000", gnt_o, master_add_o);
    end
    exp_q.push_back(1'b0); mdl_rr = 1'b1;
    next_cycle();
    req_i = 2'b00; master_gnt_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      d = $urandom(); master_r_valid_i = 1'b1; master_r_rdata_i = d;
      @(negedge clk);
      test_response("lock_drain", d);
      next_cycle();
    end
    master_r_valid_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_full();
    test_spurious();
    test_reset_mid();
    test_contention();
    test_lock();
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_leftover: got %0d entries, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, required completion before 100000");
    $fatal(1, "timeout");
  end

endmodule
